ram_bist_ctrl: RTL and testbench

- Initiator-side controller for the team's single-port synchronous RAM (registered read data, write when we=1, read when we=0).
- On a start pulse it drives the RAM port through three write-all/read-all-compare phases.
- It reports pass/fail, plus the first failing address, data and phase.
- It sits between system control and one RAM instance and is used for power-on self-test and bring-up.

---
 rtl/ram_bist_pkg.sv | 44 ++++
 rtl/ram_bist_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_pkg
// Description : Shared types, phase codes and test-pattern generator for the
//               single-port RAM built-in self-test controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_bist_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Test phase codes, in execution order
    localparam logic [1:0] PH_CHECKER = 2'd0;
    localparam logic [1:0] PH_INV     = 2'd1;
    localparam logic [1:0] PH_ADDR    = 2'd2;

    // Widest data/address width the pattern generator supports; callers
    // truncate the result to their own DATA_W.
    localparam int PAT_W = 32;

    // Pattern written at a given address in a given phase. The checkerboard
    // has bit 0 set so that it reads 0x55.. at any width; the address pattern
    // is zero-extended, and truncation by the caller keeps its low bits.
    function automatic logic [PAT_W-1:0] pattern(input logic [1:0]       phase,
                                                 input logic [PAT_W-1:0] addr);
        logic [PAT_W-1:0] r_pat;
        r_pat = {(PAT_W/2){2'b01}};
        case (phase)
            PH_CHECKER: r_pat = {(PAT_W/2){2'b01}};
            PH_INV:     r_pat = {(PAT_W/2){2'b10}};
            default:    r_pat = addr;
        endcase
        return r_pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_ctrl
// Description : Drives a single-port synchronous RAM through three
//               write-all / read-all-compare phases (checkerboard, inverse
//               checkerboard, address-in-data) and reports pass/fail with the
//               first failing address, data and phase.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [1:0]        fail_phase,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_phase;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_cmp_en;
    logic [ADDR_W-1:0]   r_exp_addr;
    logic [DATA_W-1:0]   r_exp_data;
    logic                r_pass;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;
    logic [1:0]          r_fail_phase;
    logic [DATA_W-1:0]   w_pat;
    logic                w_mis;

    assign w_pat = DATA_W'(pattern(r_phase, PAT_W'(r_addr)));

    // The read issued last cycle returns now; compare only when one was issued
    assign w_mis = r_cmp_en && ((r_state == READ) || (r_state == DRAIN))
                   && (mem_rdata != r_exp_data);

    assign pass       = r_pass;
    assign fail_addr  = r_fail_addr;
    assign fail_data  = r_fail_data;
    assign fail_phase = r_fail_phase;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and RAM port / status outputs
    always_comb begin
        w_next    = r_state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = w_pat;
                if (r_addr == c_last_addr) w_next = READ;
            end
            READ: begin
                busy     = 1'b1;
                mem_addr = r_addr;
                if (w_mis)                      w_next = DONE;
                else if (r_addr == c_last_addr) w_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_mis || (r_phase == PH_ADDR)) w_next = DONE;
                else                               w_next = WRITE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Address/phase counters, delayed-compare pipeline and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= PH_CHECKER;
            r_addr       <= '0;
            r_cmp_en     <= 1'b0;
            r_exp_addr   <= '0;
            r_exp_data   <= '0;
            r_pass       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_fail_phase <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmp_en <= 1'b0;
                    if (start) begin
                        r_phase      <= PH_CHECKER;
                        r_addr       <= '0;
                        r_pass       <= 1'b0;
                        r_fail_addr  <= '0;
                        r_fail_data  <= '0;
                        r_fail_phase <= 2'd0;
                    end
                end
                WRITE: begin
                    // Wraps to zero after the last address, ready for READ
                    r_addr   <= r_addr + ADDR_W'(1);
                    r_cmp_en <= 1'b0;
                end
                READ: begin
                    r_addr     <= r_addr + ADDR_W'(1);
                    r_exp_addr <= r_addr;
                    r_exp_data <= w_pat;
                    r_cmp_en   <= 1'b1;
                    if (w_mis) begin
                        r_fail_addr  <= r_exp_addr;
                        r_fail_data  <= mem_rdata;
                        r_fail_phase <= r_phase;
                        r_pass       <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_cmp_en <= 1'b0;
                    r_addr   <= '0;
                    if (w_mis) begin
                        r_fail_addr  <= r_exp_addr;
                        r_fail_data  <= mem_rdata;
                        r_fail_phase <= r_phase;
                        r_pass       <= 1'b0;
                    end else if (r_phase == PH_ADDR) begin
                        r_pass <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 2'd1;
                    end
                end
                default: begin
                    r_cmp_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bist_ctrl
// Description : Directed bench for ram_bist_ctrl with a behavioural RAM that
//               can inject stuck-at and address-aliasing faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bist_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [1:0]    fail_phase;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    // 0 healthy, 1 addr5 bit0 stuck-1, 2 addr15 bit7 stuck-0, 3 ignore addr bit3
    int fault_mode = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_v;
    logic [12:0]   snap [0:255];

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .fail_phase (fail_phase),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [AW-1:0] phys(input logic [AW-1:0] a);
        return (fault_mode == 3) ? (a & 4'h7) : a;
    endfunction

    // Behavioural single-port RAM with registered read data and fault hooks
    always @(posedge clk) begin
        if (mem_we) begin
            mem[phys(mem_addr)] <= mem_wdata;
        end else begin
            rd_v = mem[phys(mem_addr)];
            if (fault_mode == 1 && mem_addr == 4'd5)  rd_v[0] = 1'b1;
            if (fault_mode == 2 && mem_addr == 4'd15) rd_v[7] = 1'b0;
            mem_rdata <= rd_v;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".done"},       32'(done),       32'd0);
        check({tag, ".pass"},       32'(pass),       32'd0);
        check({tag, ".fail_addr"},  32'(fail_addr),  32'd0);
        check({tag, ".fail_data"},  32'(fail_data),  32'd0);
        check({tag, ".fail_phase"}, 32'(fail_phase), 32'd0);
        check({tag, ".mem_we"},     32'(mem_we),     32'd0);
        check({tag, ".mem_addr"},   32'(mem_addr),   32'd0);
        check({tag, ".mem_wdata"},  32'(mem_wdata),  32'd0);
    endtask

    // Called #1 after an edge with the DUT in IDLE; that cycle is cycle 0.
    task automatic run_test(input int inj_start, input int inj_rst,
                            output int done_cyc, output int first_busy, output int last_busy);
        done_cyc   = 0;
        first_busy = 0;
        last_busy  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            snap[cyc] = {mem_we, mem_addr, mem_wdata};
            if (busy) begin
                if (first_busy == 0) first_busy = cyc;
                last_busy = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == inj_start) start = 1'b1;
            if (cyc == inj_rst) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic after_done(input string tag);
        @(posedge clk); #1;
        check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"},      32'(busy), 32'd0);
    endtask

    initial begin
        int dc, fb, lb, ndone;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Healthy RAM: full 100-cycle run
        fault_mode = 0;
        run_test(0, 0, dc, fb, lb);
        check("healthy.first_busy", 32'(fb), 32'd1);
        check("healthy.last_busy",  32'(lb), 32'd99);
        check("healthy.done_cyc",   32'(dc), 32'd100);
        check("healthy.pass",       32'(pass),       32'd1);
        check("healthy.fail_addr",  32'(fail_addr),  32'd0);
        check("healthy.fail_data",  32'(fail_data),  32'h00);
        check("healthy.fail_phase", 32'(fail_phase), 32'd0);
        check("healthy.wr_c1",      32'(snap[1]),  {19'd0, 1'b1, 4'd0, 8'h55});
        check("healthy.wr_c2",      32'(snap[2]),  {19'd0, 1'b1, 4'd1, 8'h55});
        check("healthy.rd_c17",     32'(snap[17][12:8]), {27'd0, 1'b0, 4'd0});
        check("healthy.rd_c20",     32'(snap[20][12:8]), {27'd0, 1'b0, 4'd3});
        check("healthy.wr_c34",     32'(snap[34]), {19'd0, 1'b1, 4'd0, 8'hAA});
        check("healthy.wr_c68",     32'(snap[68]), {19'd0, 1'b1, 4'd1, 8'h01});
        check("healthy.wr_c82",     32'(snap[82]), {19'd0, 1'b1, 4'd15, 8'h0F});
        after_done("healthy");
        check("healthy.pass_held",  32'(pass), 32'd1);

        // addr 5 bit0 stuck-at-1: caught reading addr 5 in phase 1
        fault_mode = 1;
        run_test(0, 0, dc, fb, lb);
        check("sa1_a5.done_cyc",   32'(dc), 32'd57);
        check("sa1_a5.pass",       32'(pass),       32'd0);
        check("sa1_a5.fail_addr",  32'(fail_addr),  32'd5);
        check("sa1_a5.fail_data",  32'(fail_data),  32'hAB);
        check("sa1_a5.fail_phase", 32'(fail_phase), 32'd1);
        after_done("sa1_a5");

        // addr 15 bit7 stuck-at-0: caught in the phase-1 drain compare
        fault_mode = 2;
        run_test(0, 0, dc, fb, lb);
        check("sa0_a15.done_cyc",   32'(dc), 32'd67);
        check("sa0_a15.pass",       32'(pass),       32'd0);
        check("sa0_a15.fail_addr",  32'(fail_addr),  32'd15);
        check("sa0_a15.fail_data",  32'(fail_data),  32'h2A);
        check("sa0_a15.fail_phase", 32'(fail_phase), 32'd1);
        after_done("sa0_a15");

        // Address bit 3 ignored: only the address pattern exposes it
        fault_mode = 3;
        run_test(0, 0, dc, fb, lb);
        check("alias.done_cyc",   32'(dc), 32'd85);
        check("alias.pass",       32'(pass),       32'd0);
        check("alias.fail_addr",  32'(fail_addr),  32'd0);
        check("alias.fail_data",  32'(fail_data),  32'h08);
        check("alias.fail_phase", 32'(fail_phase), 32'd2);
        after_done("alias");

        // start pulse mid-run is ignored
        fault_mode = 0;
        run_test(40, 0, dc, fb, lb);
        check("midstart.last_busy", 32'(lb), 32'd99);
        check("midstart.done_cyc",  32'(dc), 32'd100);
        check("midstart.pass",      32'(pass), 32'd1);
        after_done("midstart");

        // Reset at cycle 50 aborts silently and clears results
        run_test(0, 50, dc, fb, lb);
        check("midrst.no_done", 32'(dc), 32'd0);
        check_reset_outputs("midrst");
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            if (done || busy) ndone++;
            @(posedge clk); #1;
        end
        check("midrst.stays_idle", 32'(ndone), 32'd0);
        run_test(0, 0, dc, fb, lb);
        check("rerun.done_cyc", 32'(dc), 32'd100);
        check("rerun.pass",     32'(pass), 32'd1);
        after_done("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
